// File: rtl/mode_set_ctrl.sv
// ============================================================================
// Module   : mode_set_ctrl
// Purpose  : Button front-end for a clock / stopwatch / timer. Turns debounced
//            button levels into mode selection, field editing and one-cycle
//            command pulses for the active datapath.
// Options  : MODE_SET_AUTO_REPEAT_EN - when defined, up/down held alone in
//            EDIT auto-repeat o_inc/o_dec after a delay, then at a fixed rate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mode_set_ctrl #(
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned EDIT_TIMEOUT_MS = 10000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ms_pulse,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_mode,
  input  logic       i_set,
  output logic [1:0] o_mode,
  output logic       o_edit,
  output logic [1:0] o_field,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_run_toggle,
  output logic       o_clear
);

  // Button vector bit positions; higher index wins when presses coincide.
  localparam int unsigned c_B_MODE  = 5;
  localparam int unsigned c_B_SET   = 4;
  localparam int unsigned c_B_LEFT  = 3;
  localparam int unsigned c_B_RIGHT = 2;
  localparam int unsigned c_B_UP    = 1;
  localparam int unsigned c_B_DOWN  = 0;

  localparam int unsigned c_idle_w = (EDIT_TIMEOUT_MS < 2) ? 1 : $clog2(EDIT_TIMEOUT_MS + 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(EDIT_TIMEOUT_MS - 1);

  typedef enum logic {
    ST_NAV  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        field_q, field_d;
  logic [c_idle_w-1:0] idle_q, idle_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              rt_q, rt_d;
  logic              clr_q, clr_d;
  logic [5:0]        prev_q;

  logic [5:0]        w_btn;
  logic [5:0]        w_press;
  logic [5:0]        w_win;
  logic              w_any_press;
  logic              w_rpt_fire;   // auto-repeat wants an inc/dec this cycle
  logic              w_rpt_dn;     // auto-repeat direction: 1 = dec
  logic              w_rpt_busy;   // auto-repeat armed; holds the idle timer off

  assign w_btn       = {i_mode, i_set, i_left, i_right, i_up, i_down};
  assign w_press     = w_btn & ~prev_q;
  assign w_any_press = |w_press;

  // Fixed-priority pick of a single winning press; losers are simply dropped.
  always_comb begin
    w_win = '0;
    if (w_press[c_B_MODE])       w_win[c_B_MODE]  = 1'b1;
    else if (w_press[c_B_SET])   w_win[c_B_SET]   = 1'b1;
    else if (w_press[c_B_LEFT])  w_win[c_B_LEFT]  = 1'b1;
    else if (w_press[c_B_RIGHT]) w_win[c_B_RIGHT] = 1'b1;
    else if (w_press[c_B_UP])    w_win[c_B_UP]    = 1'b1;
    else if (w_press[c_B_DOWN])  w_win[c_B_DOWN]  = 1'b1;
  end

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      2'd0:    next_mode = 2'd1;
      2'd1:    next_mode = 2'd2;
      default: next_mode = 2'd0;
    endcase
  endfunction

`ifdef MODE_SET_AUTO_REPEAT_EN
  localparam int unsigned c_rpt_max = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                         : REPEAT_RATE_MS;
  localparam int unsigned c_rpt_w   = (c_rpt_max < 2) ? 1 : $clog2(c_rpt_max + 1);

  logic               rpt_active_q, rpt_active_d;
  logic               rpt_dn_q, rpt_dn_d;
  logic               rpt_first_q, rpt_first_d;
  logic [c_rpt_w-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [c_rpt_w-1:0] w_rpt_thr;
  logic               w_rpt_start;
  logic               w_rpt_alone;

  // Only an up/down press that actually wins in EDIT arms the repeat.
  assign w_rpt_start = (state_q == ST_EDIT) && (mode_q != 2'd3) && (w_win[c_B_UP] || w_win[c_B_DOWN]);
  assign w_rpt_alone = rpt_dn_q ? (w_btn == 6'b000001) : (w_btn == 6'b000010);
  assign w_rpt_thr   = rpt_first_q ? c_rpt_w'(REPEAT_DELAY_MS) : c_rpt_w'(REPEAT_RATE_MS);
  assign w_rpt_busy  = rpt_active_q;
  assign w_rpt_dn    = rpt_dn_q;

  // Repeat timer: first interval is the delay, later intervals the rate.
  always_comb begin
    rpt_active_d = rpt_active_q;
    rpt_dn_d     = rpt_dn_q;
    rpt_first_d  = rpt_first_q;
    rpt_cnt_d    = rpt_cnt_q;
    w_rpt_fire   = 1'b0;
    if (w_rpt_start) begin
      rpt_active_d = 1'b1;
      rpt_dn_d     = w_win[c_B_DOWN];
      rpt_first_d  = 1'b1;
      rpt_cnt_d    = '0;
    end else if (rpt_active_q) begin
      if ((state_q != ST_EDIT) || w_any_press || !w_rpt_alone) begin
        rpt_active_d = 1'b0;
        rpt_cnt_d    = '0;
      end else if (i_ms_pulse) begin
        if ((rpt_cnt_q + c_rpt_w'(1)) >= w_rpt_thr) begin
          w_rpt_fire  = 1'b1;
          rpt_first_d = 1'b0;
          rpt_cnt_d   = '0;
        end else if (rpt_cnt_q != '1) begin
          rpt_cnt_d = rpt_cnt_q + c_rpt_w'(1);
        end
      end
    end
  end

  // Repeat state registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rpt_active_q <= 1'b0;
      rpt_dn_q     <= 1'b0;
      rpt_first_q  <= 1'b0;
      rpt_cnt_q    <= '0;
    end else begin
      rpt_active_q <= rpt_active_d;
      rpt_dn_q     <= rpt_dn_d;
      rpt_first_q  <= rpt_first_d;
      rpt_cnt_q    <= rpt_cnt_d;
    end
  end
`else
  // Repeat timing parameters only matter when auto-repeat is built in.
  if ((REPEAT_DELAY_MS == 0) || (REPEAT_RATE_MS == 0)) begin : g_repeat_unused
  end

  assign w_rpt_fire = 1'b0;
  assign w_rpt_dn   = 1'b0;
  assign w_rpt_busy = 1'b0;
`endif

  // Next-state and command decode for the NAV/EDIT controller.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    field_d = field_q;
    idle_d  = idle_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    rt_d    = 1'b0;
    clr_d   = 1'b0;
    if (mode_q == 2'd3) begin
      // Unreachable encoding: fall back to a known-good state.
      state_d = ST_NAV;
      mode_d  = 2'd0;
      field_d = 2'd0;
      idle_d  = '0;
    end else begin
      case (state_q)
        ST_NAV: begin
          idle_d  = '0;
          field_d = 2'd0;
          if (w_win[c_B_MODE]) begin
            mode_d = next_mode(mode_q);
          end else if (w_win[c_B_SET]) begin
            if (mode_q == 2'd1) begin
              rt_d = 1'b1;
            end else begin
              state_d = ST_EDIT;
              field_d = 2'd0;
            end
          end else if (w_win[c_B_UP]) begin
            rt_d = (mode_q == 2'd2);
          end else if (w_win[c_B_DOWN]) begin
            clr_d = (mode_q != 2'd0);
          end
        end
        ST_EDIT: begin
          if (w_win[c_B_MODE]) begin
            state_d = ST_NAV;
            mode_d  = next_mode(mode_q);
            field_d = 2'd0;
          end else if (w_win[c_B_SET]) begin
            state_d = ST_NAV;
            field_d = 2'd0;
          end else if (w_win[c_B_LEFT]) begin
            field_d = (field_q >= 2'd2) ? 2'd0 : field_q + 2'd1;
          end else if (w_win[c_B_RIGHT]) begin
            case (field_q)
              2'd0:    field_d = 2'd2;
              2'd1:    field_d = 2'd0;
              2'd2:    field_d = 2'd1;
              default: field_d = 2'd0;
            endcase
          end else if (w_win[c_B_UP]) begin
            inc_d = 1'b1;
          end else if (w_win[c_B_DOWN]) begin
            dec_d = 1'b1;
          end else if (w_rpt_fire) begin
            inc_d = ~w_rpt_dn;
            dec_d = w_rpt_dn;
          end
          // Inactivity timer: any press or live repeat counts as activity.
          if (w_any_press || w_rpt_busy) begin
            idle_d = '0;
          end else if (i_ms_pulse) begin
            if (idle_q >= c_idle_last) begin
              state_d = ST_NAV;
              field_d = 2'd0;
              idle_d  = '0;
            end else begin
              idle_d = idle_q + c_idle_w'(1);
            end
          end
        end
        default: begin
          state_d = ST_NAV;
          mode_d  = 2'd0;
          field_d = 2'd0;
          idle_d  = '0;
        end
      endcase
    end
  end

  // State, counters, previous button levels and registered command pulses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_NAV;
      mode_q  <= 2'd0;
      field_q <= 2'd0;
      idle_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      rt_q    <= 1'b0;
      clr_q   <= 1'b0;
      prev_q  <= '1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      field_q <= field_d;
      idle_q  <= idle_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      rt_q    <= rt_d;
      clr_q   <= clr_d;
      prev_q  <= w_btn;
    end
  end

  assign o_mode       = mode_q;
  assign o_edit       = (state_q == ST_EDIT);
  assign o_field      = field_q;
  assign o_inc        = inc_q;
  assign o_dec        = dec_q;
  assign o_run_toggle = rt_q;
  assign o_clear      = clr_q;

endmodule

`default_nettype wire

// File: tb/tb_mode_set_ctrl.sv
// ============================================================================
// Module   : tb_mode_set_ctrl
// Purpose  : Directed bench for mode_set_ctrl: a table of single-press
//            vectors plus hand sequences for timeout, auto-repeat and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mode_set_ctrl;

  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_MODE  = 6'b100000;
  localparam logic [5:0] B_SET   = 6'b010000;
  localparam logic [5:0] B_LEFT  = 6'b001000;
  localparam logic [5:0] B_RIGHT = 6'b000100;
  localparam logic [5:0] B_UP    = 6'b000010;
  localparam logic [5:0] B_DOWN  = 6'b000001;

  logic       clk;
  logic       rstn;
  logic       ms;
  logic [5:0] btn;
  logic [1:0] o_mode;
  logic       o_edit;
  logic [1:0] o_field;
  logic       o_inc, o_dec, o_rt, o_clr;

  int n_tests = 0;
  int n_fail  = 0;

  mode_set_ctrl #(
    .REPEAT_DELAY_MS (5),
    .REPEAT_RATE_MS  (2),
    .EDIT_TIMEOUT_MS (20)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_ms_pulse   (ms),
    .i_up         (btn[1]),
    .i_down       (btn[0]),
    .i_left       (btn[3]),
    .i_right      (btn[2]),
    .i_mode       (btn[5]),
    .i_set        (btn[4]),
    .o_mode       (o_mode),
    .o_edit       (o_edit),
    .o_field      (o_field),
    .o_inc        (o_inc),
    .o_dec        (o_dec),
    .o_run_toggle (o_rt),
    .o_clear      (o_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] b;
    logic [1:0] mode;
    logic       edit;
    logic [1:0] field;
    logic       inc;
    logic       dec;
    logic       rt;
    logic       clr;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [0:NV-1];

  task automatic check(input string tag, input logic [1:0] m, input logic e,
                       input logic [1:0] f, input logic inc, input logic dec,
                       input logic rt, input logic clr);
    logic [8:0] got, exp;
    got = {o_mode, o_edit, o_field, o_inc, o_dec, o_rt, o_clr};
    exp = {m, e, f, inc, dec, rt, clr};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got mode=%0d edit=%b field=%0d inc/dec/rt/clr=%b%b%b%b, want mode=%0d edit=%b field=%0d inc/dec/rt/clr=%b%b%b%b",
               tag, o_mode, o_edit, o_field, o_inc, o_dec, o_rt, o_clr,
               m, e, f, inc, dec, rt, clr);
    end
  endtask

  // Hold inputs for exactly one rising edge, then sample just after it.
  task automatic drive(input logic [5:0] b, input logic p);
    @(negedge clk);
    btn = b;
    ms  = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single-press vectors with hand-derived results, starting in mode 0 / NAV.
    //            btn            mode  ed  fld   inc  dec  rt   clr
    vecs[0]  = '{B_MODE,         2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{B_MODE,         2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{B_MODE,         2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{B_SET,          2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{B_LEFT,         2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{B_LEFT,         2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{B_UP,           2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{B_LEFT,         2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{B_RIGHT,        2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{B_DOWN,         2'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{B_SET,          2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{B_UP,           2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{B_MODE,         2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{B_SET | B_DOWN, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{B_DOWN,         2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{B_UP,           2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{B_LEFT,         2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{B_MODE,         2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{B_UP,           2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{B_DOWN,         2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{B_SET,          2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{B_MODE | B_UP,  2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{B_SET,          2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{B_UP | B_DOWN,  2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{B_LEFT|B_RIGHT, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{B_MODE,         2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    rstn = 1'b0;
    btn  = B_NONE;
    ms   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    drive(B_NONE, 1'b0);
    check("post_reset_idle", 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].b, 1'b0);
      check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].edit, vecs[i].field,
            vecs[i].inc, vecs[i].dec, vecs[i].rt, vecs[i].clr);
      drive(B_NONE, 1'b0);
      check($sformatf("vec%0d_release", i), vecs[i].mode, vecs[i].edit, vecs[i].field,
            1'b0, 1'b0, 1'b0, 1'b0);
    end

    // EDIT timeout of 20 ms pulses, restarted by a press on pulse 19.
    drive(B_MODE, 1'b0);
    drive(B_NONE, 1'b0);
    drive(B_SET, 1'b0);
    drive(B_NONE, 1'b0);
    check("to_enter", 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      drive(B_NONE, 1'b1);
      drive(B_NONE, 1'b0);
    end
    check("to_after18", 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(B_UP, 1'b1);
    check("to_press19", 2'd2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(B_NONE, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      drive(B_NONE, 1'b1);
      drive(B_NONE, 1'b0);
    end
    check("to_after19", 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(B_NONE, 1'b1);
    check("to_fire20", 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Up held for 10 ms in EDIT: repeats at ms 5, 7, 9 only when built in.
    drive(B_MODE, 1'b0);
    drive(B_NONE, 1'b0);
    drive(B_SET, 1'b0);
    drive(B_NONE, 1'b0);
    check("rpt_enter", 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(B_UP, 1'b0);
    check("rpt_press", 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic exp_inc;
`ifdef MODE_SET_AUTO_REPEAT_EN
      exp_inc = (k == 5) || (k == 7) || (k == 9);
`else
      exp_inc = 1'b0;
`endif
      drive(B_UP, 1'b1);
      check($sformatf("rpt_ms%0d", k), 2'd0, 1'b1, 2'd0, exp_inc, 1'b0, 1'b0, 1'b0);
      drive(B_UP, 1'b0);
      check($sformatf("rpt_gap%0d", k), 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(B_NONE, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      drive(B_NONE, 1'b1);
      check($sformatf("rpt_released%0d", k), 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(B_SET, 1'b0);
    check("rpt_exit", 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(B_NONE, 1'b0);

    // Asynchronous reset mid-EDIT / mid-repeat, with set held across release.
    drive(B_SET, 1'b0);
    drive(B_NONE, 1'b0);
    drive(B_LEFT, 1'b0);
    check("rst_pre_field", 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(B_UP, 1'b0);
    check("rst_pre_inc", 2'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    btn  = B_SET;
    rstn = 1'b0;
    #1;
    check("rst_async", 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(B_SET, 1'b0);
      check($sformatf("rst_set_held%0d", k), 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(B_NONE, 1'b0);
    drive(B_SET, 1'b0);
    check("rst_set_repress", 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(B_NONE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
